// File: rtl/fir_pio_engine.sv
// Single-MAC FIR engine behind the HPS PIO pair.
// Toggle req/ack protocol, software-loadable Q1.11 coefficients.
module fir_pio_engine #(
  parameter int TAPS      = 16,
  parameter int COEF_FRAC = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pio_hps2fpga,
  output logic [15:0] pio_fpga2hps,
  output logic        busy,
  output logic [15:0] sample_count
);
  localparam int PW = $clog2(TAPS);
  localparam int AW = 24 + PW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] C_PUSH  = 2'b00;
  localparam logic [1:0] C_COEF  = 2'b01;
  localparam logic [1:0] C_CLEAR = 2'b10;

  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [AW-1:0] MAXV = AW'(2047);
  localparam logic signed [AW-1:0] MINV = AW'(-2048);

  logic [15:0]       in_q;
  logic [1:0]        state;
  logic              req_q;
  logic signed [11:0] coef  [TAPS];
  logic signed [11:0] dline [TAPS];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     coef_ptr;
  logic [PW-1:0]     tap;
  logic [PW-1:0]     rd_idx;
  logic signed [AW-1:0] acc;
  logic signed [23:0]   prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] rsum;
  logic signed [AW-1:0] rsh;
  logic signed [11:0]   res;
  logic signed [11:0]   res_n;
  logic                 sat;
  logic                 sat_n;
  logic                 unused;

  assign unused = in_q[12];
  assign busy   = (state != S_IDLE);

  // x[n-k] lives k slots behind the newest sample
  assign rd_idx = (wr_ptr >= tap) ? wr_ptr - tap
                                  : wr_ptr + PW'(TAPS) - tap;
  assign prod     = coef[tap] * dline[rd_idx];
  assign prod_ext = prod;

  always_comb begin
    rsum  = acc + HALF;
    rsh   = rsum >>> COEF_FRAC;
    sat_n = 1'b0;
    res_n = rsh[11:0];
    if (rsh > MAXV) begin
      sat_n = 1'b1;
      res_n = 12'sd2047;
    end else if (rsh < MINV) begin
      sat_n = 1'b1;
      res_n = -12'sd2048;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q         <= '0;
      state        <= S_IDLE;
      req_q        <= 1'b0;
      wr_ptr       <= '0;
      coef_ptr     <= '0;
      tap          <= '0;
      acc          <= '0;
      res          <= '0;
      sat          <= 1'b0;
      sample_count <= '0;
      pio_fpga2hps <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i]  <= '0;
        dline[i] <= '0;
      end
    end else begin
      in_q <= pio_hps2fpga;
      unique case (state)
        S_IDLE: begin
          if (in_q[15] != pio_fpga2hps[15]) begin
            req_q <= in_q[15];
            state <= S_DONE;
            unique case (in_q[14:13])
              C_PUSH: begin
                dline[wr_ptr] <= in_q[11:0];
                acc   <= '0;
                tap   <= '0;
                state <= S_MAC;
              end
              C_COEF: begin
                coef[coef_ptr] <= in_q[11:0];
                coef_ptr <= (coef_ptr == LAST) ? '0 : coef_ptr + 1'b1;
              end
              C_CLEAR: begin
                for (int i = 0; i < TAPS; i++) dline[i] <= '0;
                coef_ptr     <= '0;
                sample_count <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          tap <= tap + 1'b1;
          if (tap == LAST) state <= S_ROUND;
        end
        S_ROUND: begin
          res          <= res_n;
          sat          <= sat_n;
          wr_ptr       <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          sample_count <= sample_count + 16'd1;
          state        <= S_DONE;
        end
        default: begin
          pio_fpga2hps <= {req_q, sat, 2'b00, res};
          state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_pio_engine.sv
// Directed bench for fir_pio_engine (TAPS=4).
// Reference FIR model feeds a result queue checked on each ack.
module tb_fir_pio_engine;
  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hps;
  logic [15:0] f2h;
  logic        busy;
  logic [15:0] scnt;

  fir_pio_engine #(.TAPS(TAPS), .COEF_FRAC(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .pio_hps2fpga (hps),
    .pio_fpga2hps (f2h),
    .busy         (busy),
    .sample_count (scnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic req = 1'b0;
  int m_coef [TAPS];
  int m_hist [TAPS];
  int m_cptr = 0;
  int m_cnt  = 0;
  logic [12:0] exp_q [$];
  logic [12:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 0;
      m_hist[k] = 0;
    end
    m_cptr = 0;
    m_cnt  = 0;
    exp_q.delete();
    last_res = '0;
  endtask

  task automatic model_push(input int x);
    int acc;
    int r;
    logic s;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = x;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += m_coef[k] * m_hist[k];
    r = (acc + 1024) >>> 11;
    s = 1'b0;
    if (r > 2047) begin
      r = 2047;
      s = 1'b1;
    end else if (r < -2048) begin
      r = -2048;
      s = 1'b1;
    end
    exp_q.push_back({s, 12'(r)});
    m_cnt++;
  endtask

  // Called just after a rising edge; returns just after the ack edge.
  task automatic do_cmd(input logic [1:0] cmd, input int data);
    int cyc;
    if (cmd == 2'b00) model_push(data);
    else if (cmd == 2'b01) begin
      m_coef[m_cptr] = data;
      m_cptr = (m_cptr + 1) % TAPS;
    end else if (cmd == 2'b10) begin
      for (int k = 0; k < TAPS; k++) m_hist[k] = 0;
      m_cptr = 0;
      m_cnt  = 0;
    end
    req = ~req;
    hps = {req, cmd, 1'b0, 12'(data)};
    cyc = 0;
    while (f2h[15] !== req && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ack_latency", cyc, (cmd == 2'b00) ? TAPS + 4 : 3);
    if (cmd == 2'b00 && exp_q.size() > 0) last_res = exp_q.pop_front();
    check("result", {f2h[14], f2h[11:0]}, last_res);
    check("zero_bits", f2h[13:12], 2'b00);
    check("sample_count", scnt, m_cnt);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int cyc;
    model_reset();
    reset = 1'b1;
    hps   = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", f2h, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_count", scnt, 16'h0000);

    // Held req=1 after release is taken as a cmd 11
    reset = 1'b0;
    cyc = 0;
    while (f2h[15] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("post_rst_latency", cyc, 3);
    check("post_rst_word", f2h, 16'h8000);
    req = 1'b1;

    do_cmd(2'b01, 1024);
    do_cmd(2'b01, 512);
    do_cmd(2'b01, -512);
    do_cmd(2'b01, 256);
    do_cmd(2'b00, 1000);
    check("imp0", f2h[11:0], 12'd500);
    do_cmd(2'b00, 0);
    check("imp1", f2h[11:0], 12'd250);
    do_cmd(2'b00, 0);
    check("imp2", f2h[11:0], 12'hF06);
    do_cmd(2'b00, 0);
    check("imp3", f2h[14:0], 15'd125);
    do_cmd(2'b11, 0);

    do_cmd(2'b00, 700);
    do_cmd(2'b10, 0);
    do_cmd(2'b00, 0);
    check("clr_res", f2h[11:0], 12'd0);
    check("clr_count", scnt, 16'd1);
    do_cmd(2'b00, 1000);
    check("clr_coef_kept", f2h[11:0], 12'd500);

    for (int i = 0; i < 4; i++) do_cmd(2'b01, 2047);
    for (int i = 0; i < 4; i++) do_cmd(2'b00, 2047);
    check("sat_pos", f2h[14:0], 15'h47FF);
    for (int i = 0; i < 4; i++) do_cmd(2'b01, -2048);
    for (int i = 0; i < 4; i++) do_cmd(2'b00, 2047);
    check("sat_neg", f2h[14:0], 15'h4800);

    do_cmd(2'b10, 0);
    do_cmd(2'b01, 1);
    do_cmd(2'b01, 2);
    do_cmd(2'b01, 3);
    do_cmd(2'b01, 4);
    do_cmd(2'b01, 100);
    do_cmd(2'b00, 2047);
    check("wrap_res", f2h[14:0], 15'd100);

    // Reset during MAC cycle 2 of a PUSH
    req = ~req;
    hps = {req, 2'b00, 1'b0, 12'd1000};
    repeat (4) @(posedge clk);
    #1;
    check("mac_busy", busy, 1'b1);
    reset = 1'b1;
    hps   = 16'h0000;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_out", f2h, 16'h0000);
    check("midrst_count", scnt, 16'h0000);
    reset = 1'b0;
    req   = 1'b0;
    model_reset();
    repeat (TAPS + 6) @(posedge clk);
    #1;
    check("midrst_no_ack", f2h, 16'h0000);
    do_cmd(2'b01, 1024);
    do_cmd(2'b01, 512);
    do_cmd(2'b01, -512);
    do_cmd(2'b01, 256);
    do_cmd(2'b00, 1000);
    check("fresh0", f2h[11:0], 12'd500);
    do_cmd(2'b00, 0);
    check("fresh1", f2h[11:0], 12'd250);
    check("fresh_count", scnt, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_pio_engine.md
Name: fir_pio_engine

Overview:
- FPGA-side FIR engine sitting between the HPS PIO ports: consumes commands/samples from the 16-bit hps2fpga PIO, returns filtered results on the 16-bit fpga2hps PIO.
- Toggle-based request/acknowledge handshake over the PIO words; coefficients are software-loadable.
- Filter is a sequential single-MAC design, one tap per cycle.

Parameters:
- TAPS, 16, number of filter taps (legal 2..64).
- COEF_FRAC, 11, fractional bits of coefficients (Q1.11 signed 12-bit).

Ports:
- clk  in  1  system clock, same clock as HPS PIO fabric side.
- reset  in  1  synchronous, active-high reset.
- pio_hps2fpga  in  16  command word from HPS.
- pio_fpga2hps  out  16  status/result word to HPS.
- busy  out  1  high while a request is being processed (LED use).
- sample_count  out  16  number of samples filtered since reset/clear; wraps 0xFFFF->0.

Behaviour:
- Input word fields: [15] req toggle; [14:13] cmd; [12] ignored; [11:0] signed data.
- Commands:
  - cmd 00 PUSH: data is a sample.
  - cmd 01 COEF: data written to coef[coef_ptr]; coef_ptr increments, wraps TAPS-1 -> 0.
  - cmd 10 CLEAR: delay line zeroed, coef_ptr=0, sample_count=0; coefficients kept.
  - cmd 11: acknowledged, no effect.
- Output word fields: [15] ack toggle; [14] sat flag of last PUSH result; [13:12] 0; [11:0] last PUSH result (signed).
- COEF/CLEAR/cmd 11 leave [14] and [11:0] unchanged.
- pio_hps2fpga is registered once (in_q); all decoding uses in_q.
- New request is detected in IDLE when in_q[15] != ack bit.
- FSM states and transitions:
  - IDLE: on request, latch cmd/data/req into cmd_q.
    - PUSH: write sample at wr_ptr of the circular delay line (newest), go MAC.
    - COEF/CLEAR/11: perform the action in the same edge, go DONE.
  - MAC: TAPS cycles; cycle k accumulates coef[k]*x[n-k] (x[n-k] read at wr_ptr-k mod TAPS). Then go ROUND.
  - ROUND: r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, arithmetic shift (round half up). Saturate to [-2048, 2047]; sat=1 if clamped. wr_ptr advances mod TAPS. sample_count++. Go DONE.
  - DONE: update pio_fpga2hps with ack bit = latched req; go IDLE.
- Accumulator width: 24 + clog2(TAPS) bits signed; no internal overflow.
- Latency, counted as cycles from the pio_hps2fpga change to the pio_fpga2hps change:
  - PUSH: TAPS+4.
  - Other commands: 3.
- busy=1 in every state except IDLE.
- Request protocol:
  - Exactly one outstanding request; the HPS must wait for ack == req before toggling again.
  - Changes to in_q while busy are ignored until the next IDLE.
  - A double toggle while busy is lost; this is a protocol violation and is not detected.
- Reset state, applied regardless of the current state, including mid-MAC:
  - pio_fpga2hps=0, busy=0, sample_count=0.
  - Delay line, coefficients and acc all 0; wr_ptr=coef_ptr=0; in_q=0; FSM=IDLE.
  - A partial computation is discarded and no ack is issued.
- After reset, if the HPS still holds req=1, a new request is taken. Software clears req after an FPGA reset.

Test Plan:
- Reset: hold reset 3 cycles with pio_hps2fpga=0xFFFF -> pio_fpga2hps=0x0000, busy=0, sample_count=0. One cycle after release, request detected (req=1 vs ack=0); response matches cmd 11 (ack toggles to 1 after 3 cycles, data unchanged).
- Impulse response, TAPS=4:
  - COEF 1024, 512, -512, 256 (coef_ptr wraps to 0).
  - PUSH 1000, then three PUSH 0 -> results 500, 250, -250, 125; sat=0; each ack exactly TAPS+4=8 cycles after its request.
- Saturation, TAPS=4:
  - Coefs all 2047; PUSH 2047 x4 -> final result 0x7FF, bit14=1.
  - Coefs all -2048; PUSH 2047 x4 -> 0x800 (-2048), bit14=1.
- CLEAR: after a non-zero history, CLEAR then PUSH 0 -> result 0, sample_count=1; coefficients unchanged (PUSH 1000 reproduces the first impulse tap).
- Coef pointer wrap, TAPS=4: five COEF writes 1,2,3,4,100 -> coef[0]=100. Verify with impulse 2048-equivalent scaling: PUSH 2047 -> round(2047*100/2048)=100.
- Reset mid-operation: reset asserted on MAC cycle 2 -> busy=0 next cycle, no ack toggle, sample_count=0, subsequent PUSH results match a fresh filter.
